// File: rtl/digit_entry_ctrl_pkg.sv
// digit_entry_ctrl_pkg: shared FSM encoding and parameter defaults
package digit_entry_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        WAIT_REL = 2'd2
    } state_e;
    localparam int DB_CYCLES_DEF = 4;
    localparam int MAX_DIGIT_DEF = 9;
endpackage

// File: rtl/digit_entry_ctrl_btn_debounce_pulse.sv
// btn_debounce_pulse: shift-register debouncer with a one-cycle rising-edge pulse
module btn_debounce_pulse #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);
    logic [DB_CYCLES-1:0] sh_q;
    logic                 level_q;
    logic                 prev_q;
    // level only moves once the whole window agrees; prev delays it for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sh_q    <= {sh_q[DB_CYCLES-2:0], raw};
            level_q <= (&sh_q) ? 1'b1 : (~|sh_q) ? 1'b0 : level_q;
            prev_q  <= level_q;
        end
    end
    assign level = level_q;
    assign pulse = level_q & ~prev_q;
endmodule

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: debounced BCD digit editor that issues a one-cycle load strobe on enter
module digit_entry_ctrl
    import digit_entry_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int MAX_DIGIT = MAX_DIGIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_enter,
    output logic [3:0] digit,
    output logic [3:0] load_data,
    output logic       load_n
);
    localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);
    logic       inc_p, dec_p, ent_p, ent_lvl;
    state_e     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [3:0] load_data_q, load_data_d;
    logic       load_n_q, load_n_d;

    btn_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .raw(btn_inc), .level(), .pulse(inc_p)
    );
    btn_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .raw(btn_dec), .level(), .pulse(dec_p)
    );
    btn_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_ent (
        .clk(clk), .rst(rst), .raw(btn_enter), .level(ent_lvl), .pulse(ent_p)
    );

    // enter has priority over edits; WAIT_REL ignores all pulses until enter is released
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        load_data_d = load_data_q;
        load_n_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (ent_p) begin
                    state_d     = COMMIT;
                    load_data_d = digit_q;
                    load_n_d    = 1'b0;
                end else if (inc_p && !dec_p) begin
                    digit_d = (digit_q == MAX_D) ? 4'd0 : digit_q + 4'd1;
                end else if (dec_p && !inc_p) begin
                    digit_d = (digit_q == 4'd0) ? MAX_D : digit_q - 4'd1;
                end
            end
            COMMIT:   state_d = WAIT_REL;
            WAIT_REL: state_d = ent_lvl ? WAIT_REL : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // all outputs are registered so the downstream register sees glitch-free data and strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            digit_q     <= 4'd0;
            load_data_q <= 4'd0;
            load_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            load_data_q <= load_data_d;
            load_n_q    <= load_n_d;
        end
    end

    assign digit     = digit_q;
    assign load_data = load_data_q;
    assign load_n    = load_n_q;
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: directed self-checking bench for digit_entry_ctrl
module tb_digit_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_enter = 1'b0;
    logic [3:0] digit;
    logic [3:0] load_data;
    logic       load_n;
    int         n_assert = 0;
    int         n_fail = 0;
    int         strobes;

    digit_entry_ctrl #(.DB_CYCLES(4), .MAX_DIGIT(9)) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_enter(btn_enter), .digit(digit), .load_data(load_data), .load_n(load_n)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic inc, input logic dec, input logic [3:0] prev,
                         input logic [3:0] exp, input string tag);
        btn_inc = inc;
        btn_dec = dec;
        tick(5);
        chk({tag, "_early"}, digit, prev);
        tick(1);
        chk(tag, digit, exp);
        tick(2);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(8);
    endtask

    initial begin
        tick(3);
        chk("rst_digit", digit, 4'd0);
        chk("rst_load_n", {3'b0, load_n}, 4'd1);
        rst = 1'b0;
        tick(1);
        chk("post_rst_digit", digit, 4'd0);
        chk("post_rst_load_data", load_data, 4'd0);
        chk("post_rst_load_n", {3'b0, load_n}, 4'd1);

        press(1, 0, 4'd0, 4'd1, "inc1");
        press(1, 0, 4'd1, 4'd2, "inc2");
        press(1, 0, 4'd2, 4'd3, "inc3");
        press(0, 1, 4'd3, 4'd2, "dec2");
        press(0, 1, 4'd2, 4'd1, "dec1");
        press(0, 1, 4'd1, 4'd0, "dec0");
        press(0, 1, 4'd0, 4'd9, "dec_wrap");
        press(1, 0, 4'd9, 4'd0, "inc_wrap");
        press(1, 1, 4'd0, 4'd0, "inc_dec_same");

        btn_inc = 1'b1; tick(1);
        btn_inc = 1'b0; tick(1);
        btn_inc = 1'b1; tick(2);
        btn_inc = 1'b0; tick(1);
        chk("bounce_none", digit, 4'd0);
        btn_inc = 1'b1; tick(20);
        btn_inc = 1'b0; tick(8);
        chk("bounce_one", digit, 4'd1);

        for (int i = 1; i < 7; i++) press(1, 0, 4'(i), 4'(i + 1), "inc_to7");

        btn_enter = 1'b1;
        tick(5);
        chk("commit_early_load_n", {3'b0, load_n}, 4'd1);
        tick(1);
        chk("commit_load_n", {3'b0, load_n}, 4'd0);
        chk("commit_load_data", load_data, 4'd7);
        tick(1);
        chk("commit_one_cycle", {3'b0, load_n}, 4'd1);
        strobes = 0;
        for (int i = 0; i < 93; i++) begin
            btn_inc = (i >= 10 && i < 30);
            tick(1);
            if (!load_n) strobes++;
        end
        chk("hold_no_strobe", 4'(strobes), 4'd0);
        chk("hold_digit", digit, 4'd7);
        btn_enter = 1'b0;
        tick(10);
        chk("hold_load_data", load_data, 4'd7);

        press(0, 1, 4'd7, 4'd6, "dec6");
        press(0, 1, 4'd6, 4'd5, "dec5");
        press(0, 1, 4'd5, 4'd4, "dec4");

        btn_enter = 1'b1;
        btn_inc = 1'b1;
        tick(6);
        chk("sim_load_n", {3'b0, load_n}, 4'd0);
        chk("sim_load_data", load_data, 4'd4);
        chk("sim_digit", digit, 4'd4);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!load_n) strobes++;
        end
        chk("sim_one_strobe", 4'(strobes), 4'd0);
        btn_enter = 1'b0;
        btn_inc = 1'b0;
        tick(10);
        chk("sim_digit_after", digit, 4'd4);

        btn_enter = 1'b1;
        tick(6);
        chk("mid_commit_load_n", {3'b0, load_n}, 4'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_load_n", {3'b0, load_n}, 4'd1);
        chk("async_load_data", load_data, 4'd0);
        chk("async_digit", digit, 4'd0);
        btn_enter = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("post_async_load_n", {3'b0, load_n}, 4'd1);
        btn_enter = 1'b1;
        tick(6);
        chk("recommit_load_n", {3'b0, load_n}, 4'd0);
        chk("recommit_load_data", load_data, 4'd0);
        tick(1);
        chk("recommit_one_cycle", {3'b0, load_n}, 4'd1);
        btn_enter = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Upstream stage for the 4-bit load register.
- Debounces three push buttons (inc, dec, enter) and maintains an editable BCD digit 0-9.
- When enter is pressed, presents the digit on load_data and drives load_n low for exactly one clock cycle, so the downstream register captures the value.

Parameters:
- DB_CYCLES, 4: debounce shift-register length; a raw button must be stable for this many consecutive clock edges to change its debounced level.
- MAX_DIGIT, 9: highest digit value. Values wrap MAX_DIGIT<->0.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- btn_inc, input, 1: raw increment button, active-high, may bounce.
- btn_dec, input, 1: raw decrement button, active-high, may bounce.
- btn_enter, input, 1: raw commit button, active-high, may bounce.
- digit, output, 4: current edit value, registered.
- load_data, output, 4: committed value for the downstream register's in port, registered.
- load_n, output, 1: active-low one-cycle load strobe for the downstream register, registered.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - digit=0, load_data=0, load_n=1, FSM=IDLE.
  - All debounce shift registers, debounced levels and previous-level registers are 0.
- Debounce, per button:
  - sh[DB_CYCLES-1:0] shifts in the raw input on every edge.
  - db_level is registered: it sets on an edge where sh is all ones, clears on an edge where sh is all zeros, and holds otherwise.
  - db_prev is db_level delayed one cycle.
  - pulse = db_level & ~db_prev (combinational, exactly one cycle wide).
- Latency: raw input goes high before edge 1 and stays stable:
  - sh is all ones after edge DB_CYCLES.
  - db_level rises at edge DB_CYCLES+1.
  - pulse is high between edges DB_CYCLES+1 and DB_CYCLES+2.
  - The action registers at edge DB_CYCLES+2.
- FSM states: IDLE, COMMIT, WAIT_REL.
  - IDLE:
    - enter pulse -> COMMIT; load_data<=digit and load_n<=0 at the same edge.
    - Otherwise, inc pulse alone -> digit+1, with MAX_DIGIT wrapping to 0.
    - Otherwise, dec pulse alone -> digit-1, with 0 wrapping to MAX_DIGIT.
    - inc and dec pulses in the same cycle -> digit unchanged.
    - enter together with inc and/or dec -> enter wins; digit unchanged and the pre-update value is committed.
  - COMMIT (exactly one cycle): load_n<=1 at the next edge; always -> WAIT_REL.
  - WAIT_REL:
    - inc, dec and enter pulses are all ignored.
    - Transition to IDLE on the edge where the debounced enter level is 0.
    - Holding enter therefore produces exactly one strobe.
- load_data holds its last committed value until the next commit. It never changes while load_n=1, except on reset.
- Arithmetic: 4-bit unsigned. Wrap is handled by explicit compare against MAX_DIGIT/0, not by natural 4-bit overflow.
- Reset asserted mid-COMMIT forces load_n=1 at once. A partially debounced press is discarded.
- A bounce shorter than DB_CYCLES never changes db_level and never produces a pulse.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, COMMIT=2'd1, WAIT_REL=2'd2).
  - Defaults for DB_CYCLES and MAX_DIGIT.
- One sub-module, btn_debounce_pulse (parameter DB_CYCLES; ports clk, rst, raw, level, pulse), instantiated three times.
- FSM and digit datapath live in the top level.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> digit=0, load_data=0, load_n=1. Assert rst asynchronously between edges -> outputs reset without waiting for a clock.
- Wrap:
  - 3 clean inc presses from 0 -> digit=3.
  - dec from 0 -> 9.
  - inc from 9 -> 0.
  - Each digit change occurs exactly DB_CYCLES+2 edges after press start.
- Bounce: btn_inc pattern 1,0,1,1,0 followed by 1 held for 20 cycles (DB_CYCLES=4) -> exactly one increment.
- Commit: digit=7, press enter and hold for 100 cycles, pressing inc during the hold:
  - load_n=0 for exactly one cycle at edge DB_CYCLES+2, with load_data=7.
  - No further strobe, and digit stays 7.
- Simultaneous: digit=4, btn_enter and btn_inc rise on the same edge -> load_data=4 with one strobe, digit remains 4.
- Reset mid-operation: assert rst during the COMMIT cycle -> load_n=1 and load_data=0 immediately. After release, a new enter commits digit=0.
